sm_result_collector: RTL
========================

Name: sm_result_collector

Overview:
Downstream of ScoringModule_v1 and SM_feeder. Captures each finished Smith-Waterman result from both toggle lanes, pairing vld0/result0 with id0 and vld1/result1 with id1. It removes the score bias, filters results against a programmable threshold and buffers qualifying (id, score) pairs in a FIFO behind a valid/ready output port. It also tracks the best score seen and keeps overflow and drop statistics.

Parameters:
SCORE_WIDTH, 12, width of result0/result1 and of out_score.
ID_WIDTH, 48, sequence ID width. Matches SM_feeder.
DEPTH, 16, FIFO entries. Power of 2, at least 2.
ZERO, 2**(SCORE_WIDTH-1), score bias added to the raw result.
CNT_WIDTH, 16, width of drop_cnt.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
vld0  in  1  lane-0 result valid from ScoringModule. Level signal; capture is on its rising edge.
vld1  in  1  lane-1 result valid. Same rules as vld0.
result0  in  SCORE_WIDTH  signed biased lane-0 result.
result1  in  SCORE_WIDTH  signed biased lane-1 result.
id0  in  ID_WIDTH  lane-0 sequence ID from SM_feeder.
id1  in  ID_WIDTH  lane-1 sequence ID from SM_feeder.
threshold  in  SCORE_WIDTH  unsigned minimum score to keep.
clear  in  1  synchronous clear of best_*, overflow and drop_cnt.
out_valid  out  1  FIFO head is valid.
out_ready  in  1  consumer accepts the head.
out_id  out  ID_WIDTH  head sequence ID.
out_score  out  SCORE_WIDTH  head unbiased score.
count  out  $clog2(DEPTH)+1  FIFO occupancy.
best_score  out  SCORE_WIDTH  highest score seen since reset or clear.
best_id  out  ID_WIDTH  ID of best_score.
overflow  out  1  sticky flag: a qualifying result was dropped.
drop_cnt  out  CNT_WIDTH  qualifying results dropped. Saturates at all-ones.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, both pending flags cleared, vld history registers cleared. Outputs: out_valid=0, count=0, best_score=0, best_id=0, overflow=0, drop_cnt=0. out_id/out_score=0 while empty.
- Edge detect: a lane event is sampled at a posedge where vldN=1 and the registered previous vldN=0. A held-high vldN produces exactly one event.
- Capture: on a lane event, pendN<=1 and the lane's score and id are latched.
  - score = (resultN + ZERO) mod 2^SCORE_WIDTH, treated as unsigned.
  - A vld already high when rst releases produces no event, because the history register resets to 0.
- Service: one pending entry per cycle, lane 0 has priority. Simultaneous events give lane 0 at cycle N+1 and lane 1 at N+2. Each lane is guaranteed 3 or more cycles between events; a new event on a lane with pendN still set overwrites it and is not checked.
- Serviced entry, best tracking: if score > best_score (strict), best_score and best_id are updated. Ties keep the earlier ID. The filter does not apply.
- Serviced entry, filter: if score >= threshold the entry qualifies.
  - If qualifying and the FIFO is not full after the same-cycle pop, it is written.
  - If qualifying and the FIFO is full, it is dropped: overflow<=1, drop_cnt+1.
  - Non-qualifying entries are discarded silently.
- Latency: event sampled at posedge N, FIFO write at N+1 (lane 1 at N+2 on a collision). out_valid rises after that posedge (show-ahead head).
- Output handshake: pop when out_valid & out_ready. Push and pop in the same cycle leave count unchanged; at count==DEPTH a simultaneous pop frees the slot, so no drop occurs. out_id/out_score stay stable while out_valid=1 and out_ready=0. Pointers wrap modulo DEPTH.
- clear=1: best_score=0, best_id=0, overflow=0, drop_cnt=0 next cycle; FIFO contents are untouched. clear has priority over a same-cycle best update or drop increment.
- Reset mid-operation: pending and FIFO entries are lost; no output glitch beyond out_valid falling asynchronously.

Test Plan:
- ZERO=2048, threshold=20: vld0 rising, result0=-2023, id0=7 -> at N+1 count=1; out_id=7, out_score=25; best_score=25, best_id=7.
- Same-cycle rising vld0 and vld1 (scores 30 id 1, 40 id 2), out_ready=0 -> FIFO order id1 then id2; count 1 at N+1, 2 at N+2; best_id=2.
- threshold=50, score 30 -> count stays 0, best_score=30; then threshold=0, score 0 -> stored (>= boundary).
- DEPTH=16, out_ready=0, 18 qualifying results -> count=16, overflow=1, drop_cnt=2, head is the first ID. Then pulse clear -> overflow=0, drop_cnt=0, count=16.
- FIFO full with out_ready=1 during a push -> count stays 16, no drop. Equal scores 33 (id 4 then id 5) -> best_id=4.
- vld0 held high for 10 cycles -> one entry. Assert rst=0 mid-stream -> out_valid=0 and count=0 immediately.

Source files
------------

// File: rtl/sm_result_collector.sv
// rtl/sm_result_collector.sv - Smith-Waterman result collector: debias, threshold filter, FIFO, best/drop stats
module sm_result_collector #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48,
    parameter int DEPTH       = 16,
    parameter int ZERO        = 2 ** (SCORE_WIDTH - 1),
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vld0,
    input  logic                     vld1,
    input  logic [SCORE_WIDTH-1:0]   result0,
    input  logic [SCORE_WIDTH-1:0]   result1,
    input  logic [ID_WIDTH-1:0]      id0,
    input  logic [ID_WIDTH-1:0]      id1,
    input  logic [SCORE_WIDTH-1:0]   threshold,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ID_WIDTH-1:0]      out_id,
    output logic [SCORE_WIDTH-1:0]   out_score,
    output logic [$clog2(DEPTH):0]   count,
    output logic [SCORE_WIDTH-1:0]   best_score,
    output logic [ID_WIDTH-1:0]      best_id,
    output logic                     overflow,
    output logic [CNT_WIDTH-1:0]     drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ID_WIDTH + SCORE_WIDTH;
    localparam logic [SCORE_WIDTH-1:0] ZERO_V  = SCORE_WIDTH'(ZERO);
    localparam logic [CW-1:0]          DEPTH_V = CW'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX = '1;

    logic                   vld0_q, vld1_q;
    logic                   ev0, ev1;
    logic                   pend0, pend1;
    logic [SCORE_WIDTH-1:0] score0_q, score1_q;
    logic [ID_WIDTH-1:0]    id0_q, id1_q;

    logic                   serve0, serve1;
    logic                   serv_vld;
    logic [SCORE_WIDTH-1:0] serv_score;
    logic [ID_WIDTH-1:0]    serv_id;
    logic                   qualify;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    logic [EW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [EW-1:0]          head;

    // Rising-edge detect; history resets low so a vld already high at reset release is ignored.
    assign ev0 = vld0 & ~vld0_q;
    assign ev1 = vld1 & ~vld1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld0_q   <= 1'b0;
            vld1_q   <= 1'b0;
            pend0    <= 1'b0;
            pend1    <= 1'b0;
            score0_q <= '0;
            score1_q <= '0;
            id0_q    <= '0;
            id1_q    <= '0;
        end else begin
            vld0_q <= vld0;
            vld1_q <= vld1;
            // A fresh event wins over the service clear, overwriting any unserviced entry.
            if (ev0) begin
                pend0    <= 1'b1;
                score0_q <= result0 + ZERO_V;
                id0_q    <= id0;
            end else if (serve0) begin
                pend0 <= 1'b0;
            end
            if (ev1) begin
                pend1    <= 1'b1;
                score1_q <= result1 + ZERO_V;
                id1_q    <= id1;
            end else if (serve1) begin
                pend1 <= 1'b0;
            end
        end
    end

    always_comb begin
        serve0     = pend0;
        serve1     = pend1 & ~pend0;
        serv_vld   = pend0 | pend1;
        serv_score = pend0 ? score0_q : score1_q;
        serv_id    = pend0 ? id0_q : id1_q;
        qualify    = serv_vld && (serv_score >= threshold);
        full       = (count == DEPTH_V);
        pop        = out_valid & out_ready;
        push       = qualify & (~full | pop);
        drop       = qualify & full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {serv_id, serv_score};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        out_valid = (count != '0);
        head      = mem[rd_ptr];
        out_id    = out_valid ? head[EW-1:SCORE_WIDTH] : '0;
        out_score = out_valid ? head[SCORE_WIDTH-1:0] : '0;
    end

    // Statistics; clear takes priority over any same-cycle update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_score <= '0;
            best_id    <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else if (clear) begin
            best_score <= '0;
            best_id    <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (serv_vld && (serv_score > best_score)) begin
                best_score <= serv_score;
                best_id    <= serv_id;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != CNT_MAX) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule
